post_scan_ctrl: RTL and testbench



---
 rtl/post_scan_ctrl_pkg.sv | 18 +
 rtl/post_scan_ctrl.sv | 118 +++++++++++
 tb/tb_post_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/post_scan_ctrl_pkg.sv
// Shared types and sizes for the post-synaptic buffer scan sequencer.
package post_scan_ctrl_pkg;

    localparam int NUM_NRN = 18;
    localparam int IDX_W   = 5;
    localparam int STEP_W  = 7;
    localparam int WAIT_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        REQ,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/post_scan_ctrl.sv
// Walks every neuron once per timestep, fetching spikes over req/ack and
// emitting one post-buffer beat per neuron; tracks steps within a sample.
module post_scan_ctrl
    import post_scan_ctrl_pkg::*;
#(
    parameter int NUM_STEPS    = 100,
    parameter int DRAIN_CYCLES = 2,
    parameter int ACK_TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_sample_start,
    input  logic              i_step_start,
    input  logic              i_nrn_ack,
    input  logic              i_nrn_spike,
    output logic              o_nrn_req,
    output logic [IDX_W-1:0]  o_nrn_idx,
    output logic              o_pb_valid,
    output logic              o_pb_spike,
    output logic [IDX_W-1:0]  o_pb_idx,
    output logic              o_pb_cnt_clr,
    output logic              o_step_done,
    output logic              o_sample_done,
    output logic [STEP_W-1:0] o_step_cnt,
    output logic              o_busy,
    output logic              o_err,
    output state_t            dbg_state
);

    // Handshake: o_nrn_req stays high while in REQ; the cycle in which
    // i_nrn_ack is high (with o_nrn_req high) transfers i_nrn_spike, and
    // o_nrn_req is low in the following cycle. Acks seen without a request
    // are ignored. o_pb_valid is a single-cycle beat with no back-pressure.

    state_t              state, next_state;
    logic [IDX_W-1:0]    idx;
    logic [STEP_W-1:0]   step_cnt;
    logic [WAIT_W-1:0]   wait_cnt;
    logic                spike;
    logic                clr_pend;
    logic                skip;
    logic                err;
    logic                step_skip;
    logic                last_nrn;
    logic                last_step;
    logic                clr_entry;

    assign last_nrn  = (idx == IDX_W'(NUM_NRN - 1));
    assign last_step = (step_cnt == STEP_W'(NUM_STEPS - 1));
    // A sample restart anywhere in the scan turns this step's DONE into a no-op.
    assign step_skip = skip | i_sample_start;
    assign clr_entry = (state == IDLE) && (next_state == CLR);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (i_step_start) next_state = (clr_pend || i_sample_start) ? CLR : REQ;
            CLR:   next_state = REQ;
            REQ:   if (i_nrn_ack || (wait_cnt == WAIT_W'(ACK_TIMEOUT))) next_state = ISSUE;
            ISSUE: next_state = last_nrn ? DRAIN : REQ;
            DRAIN: if (wait_cnt == WAIT_W'(DRAIN_CYCLES - 1)) next_state = DONE;
            DONE:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            idx      <= '0;
            step_cnt <= '0;
            wait_cnt <= '0;
            spike    <= 1'b0;
            clr_pend <= 1'b0;
            skip     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state <= next_state;
            // One counter serves both the ack timeout and the drain wait.
            if ((state != next_state) || (state == IDLE)) wait_cnt <= '0;
            else                                          wait_cnt <= wait_cnt + 1'b1;

            if ((state == REQ) && (next_state == ISSUE)) begin
                spike <= i_nrn_ack & i_nrn_spike;
                if (!i_nrn_ack) err <= 1'b1;
            end

            if (state == ISSUE) idx <= last_nrn ? '0 : idx + 1'b1;

            if (clr_entry) clr_pend <= 1'b0;

            if (state == DONE) begin
                skip <= 1'b0;
                if (!step_skip) step_cnt <= last_step ? '0 : step_cnt + 1'b1;
            end

            if (i_sample_start) begin
                step_cnt <= '0;
                if (!clr_entry) clr_pend <= 1'b1;
                if ((state != IDLE) && (state != DONE)) skip <= 1'b1;
            end
        end
    end

    assign o_nrn_req     = (state == REQ);
    assign o_nrn_idx     = idx;
    assign o_pb_valid    = (state == ISSUE);
    assign o_pb_spike    = (state == ISSUE) & spike;
    assign o_pb_idx      = idx;
    assign o_pb_cnt_clr  = (state == CLR);
    assign o_step_done   = (state == DONE);
    assign o_sample_done = (state == DONE) && !step_skip && last_step;
    assign o_step_cnt    = step_cnt;
    assign o_busy        = (state != IDLE);
    assign o_err         = err;
    assign dbg_state     = state;

endmodule

// File: tb/tb_post_scan_ctrl.sv
// Randomised scan scenarios checked against a per-step model of beats,
// timing, step counting and error reporting.
module tb_post_scan_ctrl;
    import post_scan_ctrl_pkg::*;

    localparam int NS = 3;
    localparam int DR = 2;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_sample_start, i_step_start, i_nrn_ack, i_nrn_spike;
    logic              o_nrn_req, o_pb_valid, o_pb_spike, o_pb_cnt_clr;
    logic              o_step_done, o_sample_done, o_busy, o_err;
    logic [IDX_W-1:0]  o_nrn_idx, o_pb_idx;
    logic [STEP_W-1:0] o_step_cnt;
    state_t            dbg_state;

    int   total = 0;
    int   bad   = 0;
    int   dly[NUM_NRN];
    logic spk[NUM_NRN];
    int   wcnt;
    int   m_step_cnt;
    bit   m_clr_pend;
    bit   m_err;
    logic [5:0] exp_q[$];

    post_scan_ctrl #(.NUM_STEPS(NS), .DRAIN_CYCLES(DR), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset),
        .i_sample_start(i_sample_start), .i_step_start(i_step_start),
        .i_nrn_ack(i_nrn_ack), .i_nrn_spike(i_nrn_spike),
        .o_nrn_req(o_nrn_req), .o_nrn_idx(o_nrn_idx),
        .o_pb_valid(o_pb_valid), .o_pb_spike(o_pb_spike), .o_pb_idx(o_pb_idx),
        .o_pb_cnt_clr(o_pb_cnt_clr), .o_step_done(o_step_done),
        .o_sample_done(o_sample_done), .o_step_cnt(o_step_cnt),
        .o_busy(o_busy), .o_err(o_err), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    // Neuron unit model: acks after dly[idx] cycles of request; dly > TO never acks.
    task automatic respond();
        if (o_nrn_req && (int'(o_nrn_idx) < NUM_NRN)) begin
            if (wcnt == dly[o_nrn_idx]) begin
                i_nrn_ack   = 1'b1;
                i_nrn_spike = spk[o_nrn_idx];
            end else begin
                i_nrn_ack   = 1'b0;
                i_nrn_spike = 1'($urandom_range(0, 1));
                wcnt++;
            end
        end else begin
            i_nrn_ack   = 1'b0;
            i_nrn_spike = 1'($urandom_range(0, 1));
            wcnt        = 0;
        end
    endtask

    task automatic randomize_nrn(input int max_dly);
        for (int i = 0; i < NUM_NRN; i++) begin
            dly[i] = $urandom_range(0, max_dly);
            spk[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic scan(input bit start_sample, input int mid_idx, input bit extra_step,
                        input string name);
        int   c, exp_done, clr_seen, eff;
        int   req_cyc[NUM_NRN];
        bit   exp_clr, exp_sd, mid_done, done_seen;
        logic [5:0] e;
        total++;
        if (o_step_cnt !== STEP_W'(m_step_cnt)) begin
            bad++;
            $display("FAIL %s step_cnt_before: got %0d want %0d", name, o_step_cnt, m_step_cnt);
        end
        if (start_sample) m_step_cnt = 0;
        exp_clr  = m_clr_pend || start_sample;
        exp_sd   = (mid_idx < 0) && (m_step_cnt == NS - 1);
        exp_done = (exp_clr ? 1 : 0) + DR;
        exp_q.delete();
        for (int i = 0; i < NUM_NRN; i++) begin
            eff = (dly[i] > TO) ? TO : dly[i];
            exp_done += eff + 2;
            req_cyc[i] = 0;
            exp_q.push_back({5'(i), (dly[i] > TO) ? 1'b0 : spk[i]});
            if (dly[i] > TO) m_err = 1'b1;
        end
        clr_seen = 0; mid_done = 0; done_seen = 0; wcnt = 0;
        @(negedge clk);
        i_step_start   = 1'b1;
        i_sample_start = start_sample;
        @(negedge clk);
        i_step_start   = 1'b0;
        i_sample_start = 1'b0;
        c = 0;
        while (!done_seen && c < 1000) begin
            if (o_pb_cnt_clr) begin
                clr_seen++;
                total++;
                if (c != 0 || o_pb_valid) begin
                    bad++;
                    $display("FAIL %s clr_timing: got cycle=%0d valid=%0b want cycle=0 valid=0",
                             name, c, o_pb_valid);
                end
            end
            if (o_pb_valid) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL %s extra_beat: got idx=%0d want no beat", name, o_pb_idx);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_pb_idx, o_pb_spike} !== e) begin
                        bad++;
                        $display("FAIL %s beat: got idx=%0d spike=%0b want idx=%0d spike=%0b",
                                 name, o_pb_idx, o_pb_spike, e[5:1], e[0]);
                    end
                end
            end
            if (o_nrn_req && (int'(o_nrn_idx) < NUM_NRN)) req_cyc[o_nrn_idx]++;
            total++;
            if (o_step_done) begin
                done_seen = 1;
                if (c != exp_done) begin
                    bad++;
                    $display("FAIL %s done_time: got %0d want %0d", name, c, exp_done);
                end
                total++;
                if (o_sample_done !== exp_sd) begin
                    bad++;
                    $display("FAIL %s sample_done: got %0b want %0b", name, o_sample_done, exp_sd);
                end
            end else if (o_sample_done !== 1'b0) begin
                bad++;
                $display("FAIL %s stray_sample_done: got 1 want 0 at cycle %0d", name, c);
            end
            i_sample_start = 1'b0;
            if (mid_idx >= 0 && !mid_done && o_nrn_req && o_nrn_idx == 5'(mid_idx)) begin
                i_sample_start = 1'b1;
                mid_done = 1;
            end
            i_step_start = extra_step && (c == 5);
            respond();
            c++;
            @(negedge clk);
        end
        i_sample_start = 1'b0;
        i_step_start   = 1'b0;
        i_nrn_ack      = 1'b0;
        if (!done_seen) begin
            total++;
            bad++;
            $display("FAIL %s step_done_timeout: got none want pulse within 1000 cycles", name);
        end
        m_step_cnt = (mid_idx >= 0) ? 0 : (m_step_cnt + 1) % NS;
        m_clr_pend = (mid_idx >= 0);
        total++;
        if (exp_q.size() != 0 || clr_seen != (exp_clr ? 1 : 0)) begin
            bad++;
            $display("FAIL %s beats_clr: got missing=%0d clr=%0d want missing=0 clr=%0d",
                     name, exp_q.size(), clr_seen, exp_clr);
        end
        for (int i = 0; i < NUM_NRN; i++) begin
            eff = (dly[i] > TO) ? TO : dly[i];
            total++;
            if (req_cyc[i] != eff + 1) begin
                bad++;
                $display("FAIL %s req_hold[%0d]: got %0d want %0d", name, i, req_cyc[i], eff + 1);
            end
        end
        total++;
        if (o_step_cnt !== STEP_W'(m_step_cnt) || o_err !== m_err || o_busy !== 1'b0) begin
            bad++;
            $display("FAIL %s end_state: got cnt=%0d err=%0b busy=%0b want cnt=%0d err=%0b busy=0",
                     name, o_step_cnt, o_err, o_busy, m_step_cnt, m_err);
        end
    endtask

    task automatic test_reset();
        int c;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({o_nrn_req, o_nrn_idx, o_pb_valid, o_pb_spike, o_pb_idx, o_pb_cnt_clr, o_step_done,
             o_sample_done, o_step_cnt, o_busy, o_err} !== 25'd0) begin
            bad++;
            $display("FAIL reset_outputs: got nonzero outputs want all 0");
        end
        reset = 1'b0;
        randomize_nrn(2);
        dly[2] = 99;
        @(negedge clk);
        i_step_start = 1'b1;
        @(negedge clk);
        i_step_start = 1'b0;
        wcnt = 0;
        c = 0;
        while (!(o_nrn_req && o_nrn_idx == 5'd7) && c < 500) begin
            respond();
            c++;
            @(negedge clk);
        end
        total++;
        if (!(o_nrn_req && o_nrn_idx == 5'd7) || o_err !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset_req7: got req=%0b idx=%0d err=%0b want req=1 idx=7 err=1",
                     o_nrn_req, o_nrn_idx, o_err);
        end
        reset     = 1'b1;
        i_nrn_ack = 1'b0;
        @(negedge clk);
        total++;
        if (dbg_state !== IDLE || {o_nrn_req, o_nrn_idx, o_pb_valid, o_pb_spike, o_pb_idx,
            o_pb_cnt_clr, o_step_done, o_sample_done, o_step_cnt, o_busy, o_err} !== 25'd0) begin
            bad++;
            $display("FAIL reset_mid_req: got state=%0d idx=%0d err=%0b busy=%0b want IDLE, all 0",
                     dbg_state, o_nrn_idx, o_err, o_busy);
        end
        reset = 1'b0;
        m_step_cnt = 0;
        m_clr_pend = 0;
        m_err      = 0;
    endtask

    task automatic test_first_scan();
        for (int i = 0; i < NUM_NRN; i++) begin
            dly[i] = 0;
            spk[i] = 1'b0;
        end
        spk[3]  = 1'b1;
        spk[17] = 1'b1;
        scan(1'b1, -1, 1'b0, "first_scan");
    endtask

    task automatic test_ack_delay();
        randomize_nrn(3);
        dly[9] = 5;
        scan(1'b0, -1, 1'b0, "ack_delay");
    endtask

    task automatic test_timeout();
        randomize_nrn(3);
        dly[4] = 99;
        scan(1'b0, -1, 1'b0, "timeout");
    endtask

    task automatic test_steps();
        randomize_nrn(2);
        scan(1'b1, -1, 1'b0, "steps_1");
        randomize_nrn(2);
        scan(1'b0, -1, 1'b0, "steps_2");
        randomize_nrn(2);
        scan(1'b0, -1, 1'b0, "steps_3");
    endtask

    task automatic test_mid_sample();
        randomize_nrn(1);
        scan(1'b0, -1, 1'b0, "mid_pre_1");
        randomize_nrn(1);
        scan(1'b0, -1, 1'b0, "mid_pre_2");
        randomize_nrn(2);
        scan(1'b0, 10, 1'b1, "mid_sample");
    endtask

    task automatic test_back_to_back();
        randomize_nrn(2);
        scan(1'b0, -1, 1'b0, "back_to_back");
    endtask

    initial begin
        reset          = 1'b1;
        i_sample_start = 1'b0;
        i_step_start   = 1'b0;
        i_nrn_ack      = 1'b0;
        i_nrn_spike    = 1'b0;
        m_step_cnt     = 0;
        m_clr_pend     = 0;
        m_err          = 0;
        test_reset();
        test_first_scan();
        test_ack_delay();
        test_timeout();
        test_steps();
        test_mid_sample();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
